// File: rtl/lcd_bus_sequencer.sv
// Times each HD44780 access (address setup, E pulse, hold) and then polls the busy flag until it clears.
// One command in flight at a time; cmd_ready is high only while idle, so upstream holds cmd_valid until accepted.
module lcd_bus_sequencer #(
    parameter int T_AS      = 3,
    parameter int T_EW      = 12,
    parameter int T_H       = 2,
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 8192
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       timeout_err,
    input  logic       err_clr,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_data_out,
    output logic       LCD_data_oe,
    input  logic [7:0] LCD_data_in
);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_EHI, A_HOLD, P_SETUP, P_EHI, P_HOLD, P_GAP
    } state_t;

    // Phase counter is loaded with length-1 and the phase ends when it reaches zero.
    localparam logic [15:0] C_AS  = 16'(T_AS - 1);
    localparam logic [15:0] C_EW  = 16'(T_EW - 1);
    localparam logic [15:0] C_H   = 16'(T_H - 1);
    localparam logic [15:0] C_GAP = 16'(POLL_GAP - 1);
    localparam logic [15:0] C_MAX = 16'(MAX_POLLS);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_polls;
    logic        r_rw;
    logic        r_busy;
    logic        r_ready;
    logic        r_rsp_vld;
    logic [7:0]  r_rsp_dat;
    logic        r_terr;
    logic        r_e;
    logic        r_rs_pin;
    logic        r_rw_pin;
    logic [7:0]  r_dout;
    logic        r_oe;

    logic        w_last;
    logic [15:0] w_cnt_dec;
    logic [15:0] w_polls_nxt;

    assign w_last      = (r_cnt == 16'd0);
    assign w_cnt_dec   = r_cnt - 16'd1;
    assign w_polls_nxt = r_polls + 16'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= 16'd0;
            r_polls   <= 16'd0;
            r_rw      <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_rsp_vld <= 1'b0;
            r_rsp_dat <= 8'h00;
            r_terr    <= 1'b0;
            r_e       <= 1'b0;
            r_rs_pin  <= 1'b0;
            r_rw_pin  <= 1'b1;
            r_dout    <= 8'h00;
            r_oe      <= 1'b0;
        end else begin
            r_rsp_vld <= 1'b0;
            if (err_clr) begin
                r_terr <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_state  <= A_SETUP;
                        r_cnt    <= C_AS;
                        r_polls  <= 16'd0;
                        r_rw     <= cmd_rw;
                        r_ready  <= 1'b0;
                        r_rs_pin <= cmd_rs;
                        r_rw_pin <= cmd_rw;
                        r_dout   <= cmd_data;
                        r_oe     <= ~cmd_rw;
                    end
                end
                A_SETUP: begin
                    if (w_last) begin
                        r_state <= A_EHI;
                        r_cnt   <= C_EW;
                        r_e     <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                A_EHI: begin
                    if (w_last) begin
                        if (r_rw) begin
                            r_rsp_dat <= LCD_data_in;
                        end
                        r_rsp_vld <= r_rw;
                        r_state   <= A_HOLD;
                        r_cnt     <= C_H;
                        r_e       <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                A_HOLD: begin
                    // Bus may only switch to poll values once the hold time has elapsed.
                    if (w_last) begin
                        r_state  <= P_SETUP;
                        r_cnt    <= C_AS;
                        r_rs_pin <= 1'b0;
                        r_rw_pin <= 1'b1;
                        r_oe     <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                P_SETUP: begin
                    if (w_last) begin
                        r_state <= P_EHI;
                        r_cnt   <= C_EW;
                        r_e     <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                P_EHI: begin
                    if (w_last) begin
                        r_busy  <= LCD_data_in[7];
                        r_state <= P_HOLD;
                        r_cnt   <= C_H;
                        r_e     <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                P_HOLD: begin
                    if (w_last) begin
                        r_polls <= w_polls_nxt;
                        if (!r_busy) begin
                            r_state <= IDLE;
                            r_cnt   <= 16'd0;
                            r_ready <= 1'b1;
                        end else if (w_polls_nxt == C_MAX) begin
                            r_terr  <= 1'b1;
                            r_state <= IDLE;
                            r_cnt   <= 16'd0;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= P_GAP;
                            r_cnt   <= C_GAP;
                        end
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                P_GAP: begin
                    if (w_last) begin
                        r_state <= P_SETUP;
                        r_cnt   <= C_AS;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 16'd0;
                    r_ready <= 1'b1;
                    r_e     <= 1'b0;
                    r_oe    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready    = r_ready;
    assign rsp_valid    = r_rsp_vld;
    assign rsp_data     = r_rsp_dat;
    assign timeout_err  = r_terr;
    assign LCD_E        = r_e;
    assign LCD_RS       = r_rs_pin;
    assign LCD_RW       = r_rw_pin;
    assign LCD_data_out = r_dout;
    assign LCD_data_oe  = r_oe;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: transaction-offset reference model, directed scenarios and randomized traffic.
// The model describes each access as a timeline of offsets from the first setup cycle.
module tb_lcd_bus_sequencer;

    localparam int T_AS = 3;
    localparam int T_EW = 12;
    localparam int T_H  = 2;
    localparam int GAP  = 4;
    localparam int MAXP = 4;
    localparam int ACC  = T_AS + T_EW + T_H;
    localparam int PER  = ACC + GAP;
    localparam int TO_T = ACC + PER * (MAXP - 1) + ACC - 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rs = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       timeout_err;
    logic       err_clr = 1'b0;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_data_out;
    logic       LCD_data_oe;
    logic [7:0] LCD_data_in = 8'h00;

    lcd_bus_sequencer #(
        .T_AS(T_AS), .T_EW(T_EW), .T_H(T_H), .POLL_GAP(GAP), .MAX_POLLS(MAXP)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rs(cmd_rs), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .timeout_err(timeout_err), .err_clr(err_clr),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_data_out(LCD_data_out), .LCD_data_oe(LCD_data_oe),
        .LCD_data_in(LCD_data_in)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: active flag, offset of current cycle, latched command.
    bit         m_active;
    int         m_t;
    logic       m_rs, m_rw, m_busy;
    logic [7:0] m_dat;
    logic       e_ready, e_E, e_RS, e_RW, e_oe, e_rsp_v, e_terr;
    logic [7:0] e_do, e_rsp_d;

    // Pad stimulus controls.
    int         busy_n = -1;
    bit         rd_fix_en = 0;
    logic [7:0] rd_fix = 8'h00;
    bit         clr_at_to = 0;
    bit         rnd_clr = 0;

    int ehi_cnt = 0;
    int rsp_cnt = 0;
    int oe_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_t = 0; m_rs = 0; m_rw = 0; m_busy = 0; m_dat = 8'h00;
        e_ready = 1; e_E = 0; e_RS = 0; e_RW = 1; e_oe = 0; e_do = 8'h00;
        e_rsp_v = 0; e_rsp_d = 8'h00; e_terr = 0;
    endtask

    task automatic model_edge();
        int  t, o, p;
        bit  to_set;
        to_set = 0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (!m_active) begin
            if (cmd_valid) begin
                m_active = 1; m_t = 0;
                m_rs = cmd_rs; m_rw = cmd_rw; m_dat = cmd_data;
            end
        end else begin
            t = m_t;
            if (m_rw && t == T_AS + T_EW - 1) e_rsp_d = LCD_data_in;
            if (t >= ACC) begin
                o = (t - ACC) % PER;
                p = (t - ACC) / PER;
                if (o == T_AS + T_EW - 1) m_busy = LCD_data_in[7];
                if (o == ACC - 1) begin
                    if (!m_busy) m_active = 0;
                    else if (p + 1 == MAXP) begin
                        m_active = 0;
                        to_set = 1;
                    end
                end
            end
            m_t = t + 1;
        end
        if (to_set) e_terr = 1;
        else if (err_clr) e_terr = 0;
        e_rsp_v = 0;
        if (!m_active) begin
            e_ready = 1; e_E = 0; e_oe = 0;
        end else begin
            e_ready = 0;
            if (m_t < ACC) begin
                e_E = (m_t >= T_AS && m_t < T_AS + T_EW);
                e_RS = m_rs; e_RW = m_rw; e_oe = ~m_rw; e_do = m_dat;
                e_rsp_v = m_rw && (m_t == T_AS + T_EW);
            end else begin
                o = (m_t - ACC) % PER;
                e_E = (o >= T_AS && o < T_AS + T_EW);
                e_RS = 0; e_RW = 1; e_oe = 0;
            end
        end
    endtask

    task automatic drive_pad();
        logic [7:0] v;
        int p;
        v = 8'($urandom);
        if (rd_fix_en && m_active && m_t < ACC) v = rd_fix;
        if (busy_n >= 0 && m_active && m_t >= ACC) begin
            p = (m_t - ACC) / PER;
            v[7] = (p < busy_n);
        end
        LCD_data_in = v;
        err_clr = (clr_at_to && m_active && m_t == TO_T) || (rnd_clr && $urandom_range(15) == 0);
    endtask

    task automatic compare();
        check("outputs",
              {9'd0, cmd_ready, LCD_E, LCD_RS, LCD_RW, LCD_data_oe, LCD_data_out, rsp_valid, rsp_data, timeout_err},
              {9'd0, e_ready, e_E, e_RS, e_RW, e_oe, e_do, e_rsp_v, e_rsp_d, e_terr});
        if (LCD_E === 1'b1) ehi_cnt++;
        if (rsp_valid === 1'b1) rsp_cnt++;
        if (LCD_data_oe === 1'b1) oe_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        drive_pad();
        @(negedge clk);
        compare();
    endtask

    // Issue one command; returns cycles from the handshake edge to cmd_ready high again.
    task automatic send(input logic rs, input logic rw, input logic [7:0] d,
                        input int bn, input bit keep, output int lat);
        busy_n = bn;
        cmd_rs = rs; cmd_rw = rw; cmd_data = d; cmd_valid = 1;
        for (int n = 0; n < 400 && !e_ready; n++) tick();
        if (!e_ready) check("handshake_wait", 32'(e_ready), 32'd1);
        ehi_cnt = 0; rsp_cnt = 0; oe_cnt = 0;
        tick();
        if (!keep) cmd_valid = 0;
        lat = 1;
        while (cmd_ready !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        model_reset();
        repeat (3) tick();
        reset_n = 1;
        check("reset_state",
              {9'd0, cmd_ready, LCD_E, LCD_RS, LCD_RW, LCD_data_oe, LCD_data_out, rsp_valid, rsp_data, timeout_err},
              {9'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
        tick();

        // Instruction write 0x38, idle LCD.
        send(1'b0, 1'b0, 8'h38, 0, 0, lat);
        check("wr38_latency", 32'(lat), 32'd35);
        check("wr38_e_cycles", 32'(ehi_cnt), 32'd24);
        check("wr38_oe_cycles", 32'(oe_cnt), 32'd17);
        check("wr38_bus_after", {29'd0, LCD_RS, LCD_RW, LCD_data_oe}, {29'd0, 1'b0, 1'b1, 1'b0});
        repeat (2) tick();

        // Data write 0x41, busy for three polls.
        send(1'b1, 1'b0, 8'h41, 3, 0, lat);
        check("wr41_latency", 32'(lat), 32'd98);
        check("wr41_e_cycles", 32'(ehi_cnt), 32'd60);
        check("wr41_oe_cycles", 32'(oe_cnt), 32'd17);
        tick();

        // Read returning 0x5A.
        rd_fix_en = 1; rd_fix = 8'h5A;
        send(1'b1, 1'b1, 8'h00, 0, 0, lat);
        rd_fix_en = 0;
        check("rd_latency", 32'(lat), 32'd35);
        check("rd_rsp_pulses", 32'(rsp_cnt), 32'd1);
        check("rd_rsp_data", 32'(rsp_data), 32'h5A);
        check("rd_oe_cycles", 32'(oe_cnt), 32'd0);
        tick();

        // Stuck busy with err_clr on the timeout edge: set must win.
        clr_at_to = 1;
        send(1'b0, 1'b0, 8'h01, 1000, 0, lat);
        clr_at_to = 0;
        check("to_latency", 32'(lat), 32'd98);
        check("to_e_cycles", 32'(ehi_cnt), 32'd60);
        check("to_flag_set", 32'(timeout_err), 32'd1);
        send(1'b0, 1'b0, 8'h0C, 0, 0, lat);
        check("after_to_latency", 32'(lat), 32'd35);
        check("to_flag_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1;
        tick();
        check("to_flag_cleared", 32'(timeout_err), 32'd0);

        // Asynchronous reset during the enable pulse.
        cmd_rs = 0; cmd_rw = 0; cmd_data = 8'hA5; cmd_valid = 1;
        for (int n = 0; n < 400 && !e_ready; n++) tick();
        tick();
        cmd_valid = 0;
        repeat (5) tick();
        check("pre_reset_e", {30'd0, LCD_E, LCD_data_oe}, {30'd0, 1'b1, 1'b1});
        #2;
        reset_n = 0;
        #1;
        check("async_reset_e_oe", {30'd0, LCD_E, LCD_data_oe}, {30'd0, 1'b0, 1'b0});
        model_reset();
        repeat (2) tick();
        reset_n = 1;
        check("post_reset_ready", 32'(cmd_ready), 32'd1);
        ehi_cnt = 0;
        repeat (40) tick();
        check("post_reset_no_poll", 32'(ehi_cnt), 32'd0);

        // Randomized traffic, mixing back-to-back and gapped commands.
        rnd_clr = 1;
        for (int i = 0; i < 60; i++) begin
            bit keep;
            keep = 1'($urandom_range(1));
            if (!keep) begin
                cmd_valid = 0;
                repeat ($urandom_range(3)) tick();
            end
            send(1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(5) - 1, keep, lat);
        end
        cmd_valid = 0;
        rnd_clr = 0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
